// File: rtl/pdm_stereo_cic.sv
// pdm_stereo_cic: stereo PDM microphone front end. Generates the PDM clock,
// decimates each channel with a 3rd-order CIC filter and queues {ch1,ch0}
// PCM frames in a small FIFO with overrun flag and level interrupt.
// Ports: clk/rst (sync, active-high); enable, period, decim, shift
// (config, latched when enable rises); fifo_thresh (irq level);
// pdm_dat/pdm_clk_o (microphone side); pcm_data/pcm_valid/pcm_ready
// (FIFO head and pop); fifo_level, overrun/clr_overrun, irq (status).
module pdm_stereo_cic #(
   parameter int NUM_CH     = 2,
   parameter int OUT_W      = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        enable,
   input  logic [7:0]                  period,
   input  logic [6:0]                  decim,
   input  logic [3:0]                  shift,
   input  logic [$clog2(FIFO_DEPTH):0] fifo_thresh,
   input  logic                        pdm_dat,
   output logic                        pdm_clk_o,
   output logic [2*OUT_W-1:0]          pcm_data,
   output logic                        pcm_valid,
   input  logic                        pcm_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overrun,
   input  logic                        clr_overrun,
   output logic                        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = 20;
   localparam int SMAX_I = (1 << (OUT_W - 1)) - 1;
   localparam int SMIN_I = -SMAX_I - 1;
   localparam logic signed [CW-1:0] SMAX = SMAX_I[CW-1:0];
   localparam logic signed [CW-1:0] SMIN = SMIN_I[CW-1:0];
   localparam logic signed [CW-1:0] P_ONE = 1;
   localparam logic signed [CW-1:0] M_ONE = -1;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t state_q, state_d;
   logic start;
   logic run;

   logic [7:0] per_q;
   logic [6:0] dec_q;
   logic [3:0] shf_q;

   logic [7:0] phase;
   logic [7:0] half;
   logic [6:0] cnt;
   logic       pend;
   logic [1:0] smp;
   logic [1:0] dump;
   logic [1:0] cgo;
   logic       push_go;
   logic       last;

   logic [OUT_W-1:0]   res0, res1;
   logic [2*OUT_W-1:0] frame;

   // ---------------- enable tracking / config latch ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         per_q   <= '0;
         dec_q   <= '0;
         shf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            per_q <= period;
            dec_q <= decim;
            shf_q <= shift;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      start   = 1'b0;
      if (!enable) begin
         state_d = S_IDLE;
      end else if (state_q == S_IDLE) begin
         state_d = S_RUN;
         start   = 1'b1;
      end
   end

   assign run  = enable && (state_q == S_RUN);
   assign half = {1'b0, per_q[7:1]};

   // ch0 is taken at the end of the PDM period, ch1 at mid-period;
   // a frame completes on the first ch1 sample after the R-th ch0 one
   always_comb begin
      smp  = '0;
      dump = '0;
      if (run) begin
         smp[0]  = (phase == per_q - 8'd1);
         smp[1]  = (NUM_CH == 2) && (phase == half - 8'd1);
         dump[0] = smp[0] && (cnt == dec_q - 7'd1);
         dump[1] = smp[1] && pend;
      end
   end

   assign last = cgo[NUM_CH-1];

   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         phase     <= '0;
         pdm_clk_o <= 1'b0;
         cnt       <= '0;
         pend      <= 1'b0;
         cgo       <= '0;
         push_go   <= 1'b0;
      end else if (run) begin
         phase     <= (phase == per_q - 8'd1) ? 8'd0 : phase + 8'd1;
         pdm_clk_o <= (phase < half);
         if (smp[0]) begin
            cnt <= dump[0] ? 7'd0 : cnt + 7'd1;
         end
         if (dump[0]) begin
            pend <= 1'b1;
         end else if (dump[1]) begin
            pend <= 1'b0;
         end
         cgo     <= dump;
         push_go <= last;
      end
   end

   // ---------------- per-channel CIC ----------------
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic signed [CW-1:0] i1, i2, i3, d1, d2, d3;
      logic signed [CW-1:0] x, n1, n2, n3, c1, c2, c3, sh;
      logic [OUT_W-1:0] sat, res;

      always_comb begin
         x  = pdm_dat ? P_ONE : M_ONE;
         n1 = i1 + x;
         n2 = i2 + n1;
         n3 = i3 + n2;
         c1 = i3 - d1;
         c2 = c1 - d2;
         c3 = c2 - d3;
         sh = c3 >>> shf_q;
         if (sh > SMAX) begin
            sat = SMAX[OUT_W-1:0];
         end else if (sh < SMIN) begin
            sat = SMIN[OUT_W-1:0];
         end else begin
            sat = sh[OUT_W-1:0];
         end
      end

      always_ff @(posedge clk) begin
         if (rst || !enable) begin
            i1 <= '0;
            i2 <= '0;
            i3 <= '0;
            d1 <= '0;
            d2 <= '0;
            d3 <= '0;
         end else begin
            if (smp[c]) begin
               i1 <= n1;
               i2 <= n2;
               i3 <= n3;
            end
            if (cgo[c]) begin
               d1 <= i3;
               d2 <= c1;
               d3 <= c2;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            res <= '0;
         end else if (cgo[c]) begin
            res <= sat;
         end
      end
   end

   assign res0 = g_ch[0].res;

   if (NUM_CH == 2) begin : g_st
      assign res1 = g_ch[1].res;
   end else begin : g_mono
      assign res1 = '0;
   end

   assign frame = {res1, res0};

   // ---------------- frame FIFO ----------------
   logic [2*OUT_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]      wp, rp;
   logic               full, pop, wr, ovf;

   assign pcm_valid = (fifo_level != '0);
   assign full      = (fifo_level == LW'(FIFO_DEPTH));
   assign pop       = pcm_valid && pcm_ready;
   // a pop in the same cycle frees the slot the push needs
   assign wr        = push_go && (!full || pop);
   assign ovf       = push_go && full && !pop;
   assign pcm_data  = pcm_valid ? mem[rp] : '0;

   always_ff @(posedge clk) begin
      if (!rst && wr) begin
         mem[wp] <= frame;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp         <= '0;
         rp         <= '0;
         fifo_level <= '0;
         overrun    <= 1'b0;
         irq        <= 1'b0;
      end else begin
         if (wr) begin
            wp <= wp + AW'(1);
         end
         if (pop) begin
            rp <= rp + AW'(1);
         end
         case ({wr, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
         if (ovf) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
         irq <= (fifo_level >= fifo_thresh) && (fifo_thresh != '0);
      end
   end

endmodule

// File: tb/tb_pdm_stereo_cic.sv
// tb_pdm_stereo_cic: scenario tasks for pdm_stereo_cic checked against a
// sample-level CIC / frame-queue model held in the bench.
module tb_pdm_stereo_cic;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [7:0]  period;
   logic [6:0]  decim;
   logic [3:0]  shift;
   logic [3:0]  fifo_thresh;
   logic        pdm_dat;
   logic        pdm_clk_o;
   logic [31:0] pcm_data;
   logic        pcm_valid;
   logic        pcm_ready;
   logic [3:0]  fifo_level;
   logic        overrun;
   logic        clr_overrun;
   logic        irq;

   int vec = 0;
   int bad = 0;

   pdm_stereo_cic #(
      .NUM_CH(2),
      .OUT_W(16),
      .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .period(period),
      .decim(decim),
      .shift(shift),
      .fifo_thresh(fifo_thresh),
      .pdm_dat(pdm_dat),
      .pdm_clk_o(pdm_clk_o),
      .pcm_data(pcm_data),
      .pcm_valid(pcm_valid),
      .pcm_ready(pcm_ready),
      .fifo_level(fifo_level),
      .overrun(overrun),
      .clr_overrun(clr_overrun),
      .irq(irq)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      int          due;
      logic [31:0] fr;
   } ev_t;

   ev_t         evq[$];
   logic [31:0] mq[$];
   int  e_n = 0;
   bit  m_run, m_pend, m_ovr, m_irq, m_clk;
   int  m_P, m_R, m_S, m_k, m_cnt;
   int  ig[2][3];
   int  dl[2][3];
   int  mout[2];

   function automatic int w20(int v);
      int t;
      t = v & 1048575;
      if (t >= 524288) t = t - 1048576;
      return t;
   endfunction

   task automatic clr_cic();
      for (int c = 0; c < 2; c++)
         for (int s = 0; s < 3; s++) begin
            ig[c][s] = 0;
            dl[c][s] = 0;
         end
   endtask

   task automatic integ(int c);
      int x;
      x = pdm_dat ? 1 : -1;
      ig[c][0] = w20(ig[c][0] + x);
      ig[c][1] = w20(ig[c][1] + ig[c][0]);
      ig[c][2] = w20(ig[c][2] + ig[c][1]);
   endtask

   task automatic comb(int c);
      int z0, z1, z2, s;
      z0 = w20(ig[c][2] - dl[c][0]);
      dl[c][0] = ig[c][2];
      z1 = w20(z0 - dl[c][1]);
      dl[c][1] = z0;
      z2 = w20(z1 - dl[c][2]);
      dl[c][2] = z1;
      s = z2 >>> m_S;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      mout[c] = s;
   endtask

   task automatic model_edge();
      int ph, sz;
      bit pop, due, ovf;
      logic [31:0] fr;
      e_n++;
      if (rst) begin
         m_run = 0; m_pend = 0; m_ovr = 0; m_irq = 0; m_clk = 0;
         m_k = 0; m_cnt = 0;
         clr_cic();
         evq.delete();
         mq.delete();
         return;
      end
      sz  = mq.size();
      pop = (sz != 0) && pcm_ready;
      due = 0;
      fr  = '0;
      if (evq.size() != 0 && evq[0].due == e_n) begin
         due = 1;
         fr  = evq[0].fr;
         void'(evq.pop_front());
      end
      m_irq = (fifo_thresh != 0) && (sz >= int'(fifo_thresh));
      if (pop) void'(mq.pop_front());
      ovf = due && (sz == DEPTH) && !pop;
      if (due && !ovf) mq.push_back(fr);
      if (ovf) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      if (!enable) begin
         m_run = 0; m_pend = 0; m_clk = 0; m_k = 0; m_cnt = 0;
         clr_cic();
         evq.delete();
      end else if (!m_run) begin
         m_run = 1;
         m_P = period; m_R = decim; m_S = shift;
         m_k = 0; m_clk = 0;
      end else begin
         ph = m_k % m_P;
         m_clk = (ph < m_P / 2);
         if (ph == m_P / 2 - 1) begin
            integ(1);
            if (m_pend) begin
               comb(1);
               m_pend = 0;
               evq.push_back('{due: e_n + 2,
                               fr: {mout[1][15:0], mout[0][15:0]}});
            end
         end
         if (ph == m_P - 1) begin
            integ(0);
            m_cnt++;
            if (m_cnt == m_R) begin
               m_cnt = 0;
               comb(0);
               m_pend = 1;
            end
         end
         m_k++;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(int p, int r, int s);
      enable = 0;
      tick();
      period = 8'(p);
      decim  = 7'(r);
      shift  = 4'(s);
      enable = 1;
      tick();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1; enable = 0; period = 0; decim = 0; shift = 0;
      fifo_thresh = 0; pdm_dat = 0; pcm_ready = 0; clr_overrun = 0;
      tick();
      tick();
      vec++;
      if (pcm_valid !== 1'b0) begin
         bad++; $display("FAIL reset_valid: got %b want 0", pcm_valid);
      end
      vec++;
      if (fifo_level !== 4'd0) begin
         bad++; $display("FAIL reset_level: got %0d want 0", fifo_level);
      end
      vec++;
      if (pcm_data !== 32'd0) begin
         bad++; $display("FAIL reset_data: got %h want 0", pcm_data);
      end
      vec++;
      if ({overrun, irq, pdm_clk_o} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got %b want 000",
                  {overrun, irq, pdm_clk_o});
      end
      rst = 0;
      tick();
   endtask

   task automatic test_clock();
      restart(4, 8, 0);
      vec++;
      if (pdm_clk_o !== 1'b0) begin
         bad++; $display("FAIL clk_latch: got %b want 0", pdm_clk_o);
      end
      for (int j = 0; j < 12; j++) begin
         tick();
         vec++;
         if (pdm_clk_o !== ((j % 4) < 2)) begin
            bad++;
            $display("FAIL clk_pattern[%0d]: got %b want %b",
                     j, pdm_clk_o, (j % 4) < 2);
         end
      end
   endtask

   task automatic test_dc(bit dat, int r, int s, logic [15:0] want);
      pdm_dat = dat;
      restart(4, r, s);
      for (int i = 0; i < 5 * r * 4 + 20; i++) tick();
      enable = 0;
      tick();
      vec++;
      if (fifo_level < 4) begin
         bad++; $display("FAIL dc_frames: got %0d want >=4", fifo_level);
      end
      for (int g = 0; g < 12 && mq.size() != 0; g++) begin
         vec++;
         if (pcm_data !== mq[0]) begin
            bad++;
            $display("FAIL dc_model[%0d]: got %h want %h", g, pcm_data, mq[0]);
         end
         if (g >= 3) begin
            vec++;
            if (pcm_data !== {want, want}) begin
               bad++;
               $display("FAIL dc_steady[%0d] r=%0d s=%0d: got %h want %h",
                        g, r, s, pcm_data, {want, want});
            end
         end
         pcm_ready = 1;
         tick();
         pcm_ready = 0;
      end
   endtask

   task automatic test_random();
      for (int round = 0; round < 2; round++) begin
         restart($urandom_range(2, 4), $urandom_range(8, 12),
                 $urandom_range(0, 5));
         for (int i = 0; i < 600; i++) begin
            pdm_dat   = 1'($urandom_range(0, 1));
            pcm_ready = ($urandom_range(0, 3) == 0);
            vec++;
            if (fifo_level !== 4'(mq.size())) begin
               bad++;
               $display("FAIL rnd_level: got %0d want %0d",
                        fifo_level, mq.size());
            end
            if (mq.size() != 0) begin
               vec++;
               if (pcm_data !== mq[0]) begin
                  bad++;
                  $display("FAIL rnd_data: got %h want %h", pcm_data, mq[0]);
               end
            end
            tick();
         end
         pcm_ready = 0;
         vec++;
         if (overrun !== m_ovr) begin
            bad++; $display("FAIL rnd_overrun: got %b want %b", overrun, m_ovr);
         end
      end
      enable = 0;
      pcm_ready = 1;
      for (int g = 0; g < 12 && mq.size() != 0; g++) tick();
      pcm_ready = 0;
      clr_overrun = 1;
      tick();
      clr_overrun = 0;
   endtask

   task automatic test_overrun();
      logic [31:0] first;
      restart(2, 8, 0);
      for (int i = 0; i < 400 && !m_ovr; i++) begin
         pdm_dat = 1'($urandom_range(0, 1));
         tick();
      end
      first = mq[0];
      vec++;
      if (overrun !== 1'b1) begin
         bad++; $display("FAIL ovr_set: got %b want 1", overrun);
      end
      vec++;
      if (fifo_level !== 4'd8) begin
         bad++; $display("FAIL ovr_level: got %0d want 8", fifo_level);
      end
      enable = 0;
      tick();
      vec++;
      if (pcm_data !== first) begin
         bad++; $display("FAIL ovr_first: got %h want %h", pcm_data, first);
      end
      pcm_ready = 1;
      tick();
      pcm_ready = 0;
      vec++;
      if (fifo_level !== 4'd7) begin
         bad++; $display("FAIL ovr_pop_level: got %0d want 7", fifo_level);
      end
      vec++;
      if (pcm_data !== mq[0]) begin
         bad++; $display("FAIL ovr_second: got %h want %h", pcm_data, mq[0]);
      end
      clr_overrun = 1;
      tick();
      clr_overrun = 0;
      vec++;
      if (overrun !== 1'b0) begin
         bad++; $display("FAIL ovr_clear: got %b want 0", overrun);
      end
   endtask

   task automatic test_irq();
      pcm_ready = 1;
      for (int g = 0; g < 12 && mq.size() != 0; g++) tick();
      pcm_ready = 0;
      fifo_thresh = 3;
      tick();
      vec++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL irq_empty: got %b want 0", irq);
      end
      restart(2, 8, 0);
      for (int i = 0; i < 300 && mq.size() < 3; i++) begin
         pdm_dat = 1'($urandom_range(0, 1));
         tick();
      end
      vec++;
      if (fifo_level !== 4'd3 || irq !== 1'b0) begin
         bad++;
         $display("FAIL irq_at3: got level %0d irq %b want 3 0",
                  fifo_level, irq);
      end
      enable = 0;
      tick();
      vec++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_rise: got %b want 1", irq);
      end
      pcm_ready = 1;
      tick();
      pcm_ready = 0;
      vec++;
      if (irq !== 1'b1) begin
         bad++; $display("FAIL irq_hold: got %b want 1", irq);
      end
      tick();
      vec++;
      if (irq !== 1'b0) begin
         bad++; $display("FAIL irq_fall: got %b want 0", irq);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      restart(2, 8, 0);
      for (int i = 0; i < 300 && mq.size() < 2; i++) begin
         pdm_dat = 1'($urandom_range(0, 1));
         tick();
      end
      for (int i = 0; i < 5; i++) tick();
      vec++;
      if (fifo_level !== 4'd2) begin
         bad++; $display("FAIL rmid_pre: got %0d want 2", fifo_level);
      end
      rst = 1;
      tick();
      rst = 0;
      vec++;
      if ({pcm_valid, fifo_level, overrun, irq, pdm_clk_o} !== 8'd0
          || pcm_data !== 32'd0) begin
         bad++;
         $display("FAIL rmid_reset: got v%b l%0d o%b i%b c%b d%h want all 0",
                  pcm_valid, fifo_level, overrun, irq, pdm_clk_o, pcm_data);
      end
      n = 0;
      while (n < 100 && !pcm_valid) begin
         tick();
         n++;
      end
      vec++;
      if (n != 8 * 2 + 1 + 3) begin
         bad++; $display("FAIL rmid_first_push: got %0d cycles want 20", n);
      end
      vec++;
      if (pcm_data !== mq[0]) begin
         bad++; $display("FAIL rmid_data: got %h want %h", pcm_data, mq[0]);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_clock();
      test_dc(1'b1, 8, 0, 16'h0200);
      test_dc(1'b0, 8, 0, 16'hFE00);
      test_dc(1'b1, 64, 0, 16'h7FFF);
      test_dc(1'b1, 64, 3, 16'h7FFF);
      test_dc(1'b1, 64, 4, 16'h4000);
      test_random();
      test_overrun();
      test_irq();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/pdm_stereo_cic.md
PDM_STEREO_CIC -- requirements
Module: pdm_stereo_cic

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning channels decoded (1 or 2).
REQ-002 SHALL have parameter OUT_W, default 16, meaning PCM sample width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8, meaning frame FIFO depth (power of 2, >=2).
REQ-004 SHALL have one clock and a synchronous active-high reset, ports in this order:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
REQ-005 SHALL have the remaining ports:
- enable  in  1  run decoder
- period  in  8  PDM clock period in clk cycles, legal >=2
- decim  in  7  decimation ratio R, legal 8..64
- shift  in  4  output right-shift
- fifo_thresh  in  $clog2(FIFO_DEPTH)+1  interrupt level
- pdm_dat  in  1  PDM data (already synchronised)
- pdm_clk_o  out  1  PDM clock to microphones
- pcm_data  out  2*OUT_W  FIFO head, {ch1,ch0}
- pcm_valid  out  1  FIFO non-empty
- pcm_ready  in  1  pop head
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored
- overrun  out  1  sticky overflow flag
- clr_overrun  in  1  clear overrun
- irq  out  1  level interrupt

Function
REQ-006 SHALL latch period, decim and shift on the cycle enable rises; changes while enable is high SHALL be ignored.
REQ-007 SHALL run phase counter 0..P-1 (P = latched period) while enabled, wrapping to 0; pdm_clk_o SHALL be registered as (phase < P>>1).
REQ-008 SHALL sample ch0 on the cycle phase==P-1 and ch1 on the cycle phase==(P>>1)-1; when NUM_CH=1, ch1 logic SHALL be absent.
REQ-009 SHALL map each sample to +1 (pdm_dat=1) or -1 (pdm_dat=0) into a 3rd-order CIC integrator chain of 20-bit two's-complement wrap-around accumulators per channel.
REQ-010 SHALL count ch0 samples; on the R-th sample it SHALL run the 3 comb stages (differential delay 1) for all channels, then reset the count to 0.
REQ-011 SHALL compute each output as comb result arithmetic-shifted right by shift, saturated to signed OUT_W.
REQ-012 SHALL push frame {ch1,ch0} (ch1 zero when NUM_CH=1) into the FIFO exactly 2 clk cycles after the ch1 sample that completes a decimation period (for NUM_CH=1, 2 cycles after the R-th ch0 sample).
REQ-013 SHALL expose the FIFO head on pcm_data with pcm_valid = (fifo_level!=0); pop SHALL occur on a cycle with pcm_valid & pcm_ready.
REQ-014 SHALL, on push and pop in the same cycle, perform both; level unchanged; when full, a simultaneous pop SHALL make room and the push SHALL succeed.
REQ-015 SHALL, on push while full without pop, drop the new frame, keep contents, and set overrun.
REQ-016 SHALL clear overrun on clr_overrun unless an overflow occurs the same cycle (set wins).
REQ-017 SHALL drive irq registered = (fifo_level >= fifo_thresh) & (fifo_thresh != 0).
REQ-018 SHALL, while enable is low, hold phase at 0, pdm_clk_o low, clear integrators, combs and decimation count, and keep FIFO contents and overrun.
REQ-019 SHALL, when enable falls mid-decimation, discard the partial frame.
REQ-020 SHALL, when pcm_ready is high while the FIFO is empty, ignore it.

Reset
REQ-021 SHALL on rst set phase, counters, integrators, combs, FIFO pointers and latched configuration to 0, pdm_clk_o=0, pcm_valid=0, fifo_level=0, overrun=0, irq=0, pcm_data=0.
REQ-022 SHALL let rst take priority over enable and all other inputs, including mid-decimation and mid-push.

Verification
REQ-023 SHALL check: period=4, enable=1 -> pdm_clk_o toggles high 2 / low 2 cycles; first rise 1 cycle after enable latches.
REQ-024 SHALL check: pdm_dat=1 constant, decim=8, shift=0 -> steady-state ch0=ch1=+512 (R^3); pdm_dat=0 -> -512.
REQ-025 SHALL check: decim=64, shift=0, pdm_dat=1 -> output saturates to 32767; shift=3 -> 32768 saturates to 32767, shift=4 -> 16384.
REQ-026 SHALL check: FIFO_DEPTH=8, pcm_ready=0 -> 8 frames then overrun=1, 9th frame dropped; pop returns first frame; clr_overrun -> overrun=0.
REQ-027 SHALL check: fifo_thresh=3 -> irq rises the cycle after level reaches 3; one pop -> irq falls next cycle.
REQ-028 SHALL check: rst asserted mid-decimation with 2 frames stored -> all outputs at reset values next cycle; no frame pushed afterwards until a full R samples elapse.
